// File: rtl/aes_req_arbiter_if.sv
// ----------------------------------------------------------------------------
// aes_req_arbiter_if
//
// Bundles every handshake and data signal between the two AES requesters,
// the arbiter and the single shared AES core.
//
// Modports
//   slave  : the arbiter's view (consumes requests and core results,
//            produces ready/response strobes and core controls)
//   master : the surrounding system's view (requesters, response sink and
//            the shared core model/instance)
//
// Signals
//   req0_valid/req1_valid   requester N has a job pending
//   req0_ready/req1_ready   job accepted this cycle (valid & ready)
//   req0_in/req1_in         plaintext, DATA_W bits
//   req0_key/req1_key       cipher key, DATA_W bits
//   resp_valid              one-cycle result strobe
//   resp_id                 requester owning the result
//   resp_data               ciphertext (0 on an aborted job)
//   resp_err                result aborted by timeout
//   core_rst                reset to the shared core
//   core_data_vaild         one-cycle start strobe to the shared core
//   core_in/core_key        operands to the shared core
//   core_out/core_ready     result and done flag from the shared core
// ----------------------------------------------------------------------------
interface aes_req_arbiter_if #(
  parameter int DATA_W = 128
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_in;
  logic [DATA_W-1:0] req0_key;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_in;
  logic [DATA_W-1:0] req1_key;

  logic              resp_valid;
  logic              resp_id;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  logic              core_rst;
  logic              core_data_vaild;
  logic [DATA_W-1:0] core_in;
  logic [DATA_W-1:0] core_key;
  logic [DATA_W-1:0] core_out;
  logic              core_ready;

  modport slave (
    input  req0_valid, req0_in, req0_key,
    input  req1_valid, req1_in, req1_key,
    input  core_out, core_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_data, resp_err,
    output core_rst, core_data_vaild, core_in, core_key
  );

  modport master (
    output req0_valid, req0_in, req0_key,
    output req1_valid, req1_in, req1_key,
    output core_out, core_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_data, resp_err,
    input  core_rst, core_data_vaild, core_in, core_key
  );
endinterface

// File: rtl/aes_req_arbiter.sv
// ----------------------------------------------------------------------------
// aes_req_arbiter
//
// Shares one AES core between two requesters. A job is accepted in IDLE,
// its plaintext/key are held for the whole job, the core is reset (CLEAR),
// started (LOAD), waited on (WAIT) and the result is strobed out (DONE).
// Arbitration between simultaneous requests is round-robin; req0 wins the
// first tie after reset.
//
// Ports
//   clk   single clock, rising edge
//   rst   synchronous, active-high reset
//   bus   aes_req_arbiter_if.slave -- requester handshakes, response
//         channel and shared-core controls
//
// Parameters
//   TIMEOUT_CYCLES  maximum number of WAIT cycles before the job is aborted
//                   with resp_err=1 and resp_data=0 (timeout build only)
//
// Configuration
//   AES_ARB_TIMEOUT_EN  when defined, WAIT is bounded by TIMEOUT_CYCLES;
//                       when undefined, WAIT lasts until core_ready and
//                       resp_err is always 0.
//
// Timing: accept-to-resp_valid spans the core latency plus the IDLE, CLEAR,
// LOAD and DONE cycles.
// ----------------------------------------------------------------------------
module aes_req_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_req_arbiter_if.slave      bus
);

  localparam int DATA_W = 128;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state;
  logic                last_grant;
  logic                grant_id;
  logic [DATA_W-1:0]   hold_in;
  logic [DATA_W-1:0]   hold_key;
  logic                core_dv_r;
  logic                resp_valid_r;
  logic                resp_id_r;
  logic [DATA_W-1:0]   resp_data_r;
  logic                resp_err_r;

  logic                pick_any;
  logic                pick_id;
  logic                accept;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0]    wait_cnt;
  logic                wait_expired;

  // Counter runs 0..TIMEOUT_CYCLES-1, so the abort lands exactly
  // TIMEOUT_CYCLES cycles after WAIT is entered.
  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic                unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Round-robin pick: on a tie, grant whoever was not granted last.
  always_comb begin
    pick_any = bus.req0_valid | bus.req1_valid;
    pick_id  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      pick_id = ~last_grant;
    end else if (bus.req1_valid) begin
      pick_id = 1'b1;
    end
  end

  // Ready has to coincide with the IDLE cycle in which the operands are
  // captured, so it is decoded from the current state rather than
  // registered; reset masks it so nothing is accepted while rst is high.
  assign accept         = (state == S_IDLE) && !rst && pick_any;
  assign bus.req0_ready = accept && !pick_id;
  assign bus.req1_ready = accept &&  pick_id;

  // The core latches its result until reset, so it is reset both with the
  // arbiter and at the start of every job.
  assign bus.core_rst        = rst | (state == S_CLEAR);
  assign bus.core_data_vaild = core_dv_r;
  assign bus.core_in         = hold_in;
  assign bus.core_key        = hold_key;

  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_id    = resp_id_r;
  assign bus.resp_data  = resp_data_r;
  assign bus.resp_err   = resp_err_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      last_grant   <= 1'b1;
      grant_id     <= 1'b0;
      hold_in      <= '0;
      hold_key     <= '0;
      core_dv_r    <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_id_r    <= 1'b0;
      resp_data_r  <= '0;
      resp_err_r   <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
      wait_cnt     <= '0;
`endif
    end else begin
      core_dv_r    <= 1'b0;
      resp_valid_r <= 1'b0;
      case (state)
        // IDLE -> CLEAR: accept the winner and capture its operands
        S_IDLE: begin
          if (pick_any) begin
            grant_id   <= pick_id;
            last_grant <= pick_id;
            hold_in    <= pick_id ? bus.req1_in  : bus.req0_in;
            hold_key   <= pick_id ? bus.req1_key : bus.req0_key;
            state      <= S_CLEAR;
          end
        end
        // CLEAR -> LOAD: core_rst is high this cycle; start strobe follows
        S_CLEAR: begin
          core_dv_r <= 1'b1;
          state     <= S_LOAD;
        end
        // LOAD -> WAIT: core_data_vaild is high this cycle
        S_LOAD: begin
`ifdef AES_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state    <= S_WAIT;
        end
        // WAIT -> DONE: capture the core result (or abort on timeout)
        S_WAIT: begin
          if (bus.core_ready) begin
            resp_data_r  <= bus.core_out;
            resp_id_r    <= grant_id;
            resp_err_r   <= 1'b0;
            resp_valid_r <= 1'b1;
            state        <= S_DONE;
          end
`ifdef AES_ARB_TIMEOUT_EN
          else if (wait_expired) begin
            resp_data_r  <= '0;
            resp_id_r    <= grant_id;
            resp_err_r   <= 1'b1;
            resp_valid_r <= 1'b1;
            state        <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        // DONE -> IDLE: resp_valid is high this cycle
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
